// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared widths, FSM states and FIFO word type for the median stream packer
package median_pkg;

   localparam int PIX_W  = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DRAIN
   } pack_state_t;

   typedef struct packed {
      logic              eol;
      logic              sof;
      logic [WORD_W-1:0] data;
   } pack_word_t;

endpackage

// File: rtl/median_stream_packer_if.sv
// rtl/median_stream_packer_if.sv - pixel strobe in, packed word stream out
interface median_stream_packer_if;
   import median_pkg::*;

   logic              done_i;
   logic [PIX_W-1:0]  median_i;
   logic [WORD_W-1:0] data_o;
   logic              sof_o;
   logic              eol_o;
   logic              valid_o;
   logic              ready_i;

   modport master (
      input  done_i, median_i, ready_i,
      output data_o, sof_o, eol_o, valid_o
   );

   modport slave (
      output done_i, median_i, ready_i,
      input  data_o, sof_o, eol_o, valid_o
   );

endinterface

// File: rtl/median_pack_fifo.sv
// rtl/median_pack_fifo.sv - first-word-fall-through FIFO of packed words
module median_pack_fifo
   import median_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  pack_word_t push_word_i,
   input  logic       pop_i,
   output pack_word_t head_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       one_left_o,
   output logic       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   pack_word_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o     = (count_q == FULL_CNT);
   assign empty_o    = (count_q == '0);
   assign one_left_o = (count_q == (AW+1)'(1));
   // Empty head reads as zero so the output bus is clean after reset.
   assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      push_ok    = push_i && (!full_o || pop_i);
      pop_ok     = pop_i && !empty_o;
      overflow_o = push_i && full_o && !pop_i;
      wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_word_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/median_stream_packer.sv
// rtl/median_stream_packer.sv - packs median pixels into 32-bit words with sof/eol and frame tracking
// Optional MEDIAN_PACK_STATS_EN adds per-frame min/max outputs.
module median_stream_packer
   import median_pkg::*;
#(
   parameter int ROWS       = 9,
   parameter int COLS       = 9,
   parameter int FIFO_DEPTH = 16
)
(
   input  logic                   clk,
   input  logic                   rst,
   median_stream_packer_if.master s,
   output logic                   frame_done_o,
   output logic                   overflow_o
`ifdef MEDIAN_PACK_STATS_EN
   ,
   output logic [PIX_W-1:0]       min_o,
   output logic [PIX_W-1:0]       max_o,
   output logic                   stats_valid_o
`endif
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
   localparam logic [1:0]    LANE_LAST = 2'(LANES - 1);

   pack_state_t       state_q;
   logic              frame_done_q;
   logic [1:0]        lane_q, lane_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [WORD_W-1:0] pack_q, pack_d, pack_next;
   logic              enq_valid_q, enq_valid_d;
   logic              enq_last_q, enq_last_d;
   pack_word_t        enq_word_q, enq_word_d, head;
   logic              sof_pend_q, sof_pend_d;
   logic              final_pend_q, final_pend_d;
   logic              overflow_q, overflow_d;
   logic              accept, col_last, row_last, final_pix, close_word;
   logic              fifo_full, fifo_empty, fifo_one_left, fifo_drop;
   logic              xfer, drain_done, drain_lost;

   median_pack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (enq_valid_q),
      .push_word_i(enq_word_q),
      .pop_i      (s.ready_i),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .one_left_o (fifo_one_left),
      .overflow_o (fifo_drop)
   );

   assign s.data_o     = head.data;
   assign s.sof_o      = head.sof;
   assign s.eol_o      = head.eol;
   assign s.valid_o    = !fifo_empty;
   assign frame_done_o = frame_done_q;
   assign overflow_o   = overflow_q;

   always_comb begin
      accept     = s.done_i && (state_q != S_DRAIN);
      col_last   = (col_q == COL_LAST);
      row_last   = (row_q == ROW_LAST);
      final_pix  = accept && col_last && row_last;
      close_word = (lane_q == LANE_LAST) || col_last;
      xfer       = s.valid_o && s.ready_i;
      // Once the final word sits in the FIFO nothing else can enter, so it leaves last.
      drain_done = (state_q == S_DRAIN) && final_pend_q && xfer && fifo_one_left;
      drain_lost = (state_q == S_DRAIN) && !final_pend_q && !enq_valid_q && fifo_empty;

      pack_next = pack_q;
      pack_next[{lane_q, 3'b000} +: PIX_W] = s.median_i;

      lane_d      = lane_q;
      col_d       = col_q;
      row_d       = row_q;
      pack_d      = pack_q;
      enq_valid_d = 1'b0;
      enq_last_d  = 1'b0;
      enq_word_d  = enq_word_q;
      sof_pend_d  = sof_pend_q;

      if (accept) begin
         if (close_word) begin
            enq_valid_d     = 1'b1;
            enq_last_d      = col_last && row_last;
            enq_word_d.eol  = col_last;
            enq_word_d.sof  = sof_pend_q;
            enq_word_d.data = pack_next;
            pack_d          = '0;
            lane_d          = '0;
            sof_pend_d      = 1'b0;
         end else begin
            pack_d = pack_next;
            lane_d = lane_q + 2'd1;
         end
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d      = '0;
               sof_pend_d = 1'b1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      final_pend_d = final_pend_q;
      if (enq_valid_q && enq_last_q && (!fifo_full || s.ready_i)) begin
         final_pend_d = 1'b1;
      end
      if (drain_done || drain_lost) begin
         final_pend_d = 1'b0;
      end

      overflow_d = overflow_q || fifo_drop || (s.done_i && (state_q == S_DRAIN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         pack_q       <= '0;
         enq_valid_q  <= 1'b0;
         enq_last_q   <= 1'b0;
         enq_word_q   <= '0;
         sof_pend_q   <= 1'b1;
         final_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pack_q       <= pack_d;
         enq_valid_q  <= enq_valid_d;
         enq_last_q   <= enq_last_d;
         enq_word_q   <= enq_word_d;
         sof_pend_q   <= sof_pend_d;
         final_pend_q <= final_pend_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef MEDIAN_PACK_STATS_EN
   logic [PIX_W-1:0] min_run_q, min_run_d, max_run_q, max_run_d;
   logic [PIX_W-1:0] min_q, min_d, max_q, max_d, min_base, max_base, min_cur, max_cur;
   logic             stats_valid_q;

   always_comb begin
      // The first pixel of a frame restarts the running extremes.
      min_base  = (state_q == S_IDLE) ? 8'hFF : min_run_q;
      max_base  = (state_q == S_IDLE) ? 8'h00 : max_run_q;
      min_cur   = (s.median_i < min_base) ? s.median_i : min_base;
      max_cur   = (s.median_i > max_base) ? s.median_i : max_base;
      min_run_d = min_run_q;
      max_run_d = max_run_q;
      min_d     = min_q;
      max_d     = max_q;
      if (accept) begin
         min_run_d = min_cur;
         max_run_d = max_cur;
      end
      if (final_pix) begin
         min_d = min_cur;
         max_d = max_cur;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_run_q <= 8'hFF;
         max_run_q <= '0;
         min_q     <= '0;
         max_q     <= '0;
      end else begin
         min_run_q <= min_run_d;
         max_run_q <= max_run_d;
         min_q     <= min_d;
         max_q     <= max_d;
      end
   end

   assign min_o         = min_q;
   assign max_o         = max_q;
   assign stats_valid_o = stats_valid_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         frame_done_q <= 1'b0;
`ifdef MEDIAN_PACK_STATS_EN
         stats_valid_q <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
`ifdef MEDIAN_PACK_STATS_EN
         stats_valid_q <= drain_done;
`endif
         case (state_q)
            S_IDLE: begin
               if (final_pix) begin
                  state_q <= S_DRAIN;
               end else if (accept) begin
                  state_q <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (final_pix) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_done) begin
                  state_q      <= S_IDLE;
                  frame_done_q <= 1'b1;
               end else if (drain_lost) begin
                  // Final word was dropped by an overflow; the frame can never complete.
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_median_stream_packer.sv
// tb/tb_median_stream_packer.sv - scoreboard bench for median_stream_packer (ROWS=3, COLS=6, FIFO_DEPTH=4)
module tb_median_stream_packer;

   logic clk = 1'b0;
   logic rst;
   logic frame_done;
   logic overflow;
`ifdef MEDIAN_PACK_STATS_EN
   logic [7:0] min_o, max_o;
   logic       stats_valid;
`endif

   int total = 0;
   int bad = 0;
   int frame_cnt = 0;
   logic [33:0] exp_q[$];
   logic [15:0] stats_q[$];
   logic        stall = 1'b0;
   logic [33:0] held;
   logic [33:0] exp_w;
   logic [15:0] st;

   always #5 clk = ~clk;

   median_stream_packer_if s();

   median_stream_packer #(.ROWS(3), .COLS(6), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .s           (s),
      .frame_done_o(frame_done),
      .overflow_o  (overflow)
`ifdef MEDIAN_PACK_STATS_EN
      ,
      .min_o       (min_o),
      .max_o       (max_o),
      .stats_valid_o(stats_valid)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int mode, input int i);
      case (mode)
         0:       return 8'(i);
         1:       return 8'hAA + 8'(17 * (i % 6));
         default: return 8'h40 + 8'(i);
      endcase
   endfunction

   // Two words per 6-pixel row: one full word, then a half word carrying eol.
   task automatic push_exp(input int mode, input int nwords);
      for (int w = 0; w < nwords; w++) begin
         int b;
         logic [33:0] e;
         b = (w / 2) * 6;
         if (w % 2 == 0) begin
            e = {1'b0, (w == 0), pix(mode, b+3), pix(mode, b+2), pix(mode, b+1), pix(mode, b)};
         end else begin
            e = {1'b1, 1'b0, 16'h0000, pix(mode, b+5), pix(mode, b+4)};
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic push_stats(input int mode);
      logic [7:0] mn, mx;
      mn = 8'hFF;
      mx = 8'h00;
      for (int i = 0; i < 18; i++) begin
         if (pix(mode, i) < mn) mn = pix(mode, i);
         if (pix(mode, i) > mx) mx = pix(mode, i);
      end
      stats_q.push_back({mn, mx});
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_valid", 64'(s.valid_o), 64'd1);
            check("hold_word", 64'({s.eol_o, s.sof_o, s.data_o}), 64'(held));
         end
         if (s.valid_o && s.ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %h expected none", {s.eol_o, s.sof_o, s.data_o});
            end else begin
               exp_w = exp_q.pop_front();
               check("word", 64'({s.eol_o, s.sof_o, s.data_o}), 64'(exp_w));
            end
         end
         stall = s.valid_o && !s.ready_i;
         held  = {s.eol_o, s.sof_o, s.data_o};
         if (frame_done) frame_cnt++;
`ifdef MEDIAN_PACK_STATS_EN
         if (frame_done || stats_valid) check("stats_sync", 64'(stats_valid), 64'(frame_done));
         if (frame_done && stats_q.size() != 0) begin
            st = stats_q.pop_front();
            check("stats_min", 64'(min_o), 64'(st[15:8]));
            check("stats_max", 64'(max_o), 64'(st[7:0]));
         end
`endif
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      s.done_i   = 1'b0;
      s.median_i = 8'h00;
      s.ready_i  = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(s.valid_o), 64'd0);
      check("rst_data", 64'(s.data_o), 64'd0);
      check("rst_sof", 64'(s.sof_o), 64'd0);
      check("rst_eol", 64'(s.eol_o), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_fdone", 64'(frame_done), 64'd0);
      rst = 1'b0;

      // Frame 1: ramp 0x00..0x11, sink always ready, check closing latency.
      s.ready_i = 1'b1;
      push_exp(0, 6);
      push_stats(0);
      for (int i = 0; i < 18; i++) begin
         s.done_i   = 1'b1;
         s.median_i = pix(0, i);
         tick();
         if (i == 3) check("lat_n1_valid", 64'(s.valid_o), 64'd0);
         if (i == 4) check("lat_n2_valid", 64'(s.valid_o), 64'd1);
      end
      s.done_i = 1'b0;
      wait_drain(60);
      repeat (3) tick();
      check("frames_after_1", 64'(frame_cnt), 64'd1);

      // Frame 2: AA..FF per row with intermittent backpressure.
      push_exp(1, 6);
      push_stats(1);
      for (int i = 0; i < 18; i++) begin
         s.done_i   = 1'b1;
         s.median_i = pix(1, i);
         s.ready_i  = (i % 3) != 0;
         tick();
      end
      s.done_i  = 1'b0;
      s.ready_i = 1'b1;
      wait_drain(60);
      repeat (3) tick();
      check("frames_after_2", 64'(frame_cnt), 64'd2);
      check("ovf_clean", 64'(overflow), 64'd0);

      // Frame 3: sink stalled; fifth word overflows, only four survive.
      s.ready_i = 1'b0;
      push_exp(0, 4);
      for (int i = 0; i < 18; i++) begin
         s.done_i   = 1'b1;
         s.median_i = pix(0, i);
         tick();
         if (i == 15) check("ovf_before", 64'(overflow), 64'd0);
         if (i == 16) check("ovf_set", 64'(overflow), 64'd1);
      end
      s.done_i = 1'b0;
      repeat (2) tick();
      s.ready_i = 1'b1;
      wait_drain(60);
      repeat (3) tick();
      check("ovf_sticky", 64'(overflow), 64'd1);
      check("frames_after_ovf", 64'(frame_cnt), 64'd2);
      check("ovf_empty", 64'(s.valid_o), 64'd0);

      // Reset mid-row 1 with three words buffered.
      s.ready_i = 1'b0;
      for (int i = 0; i < 11; i++) begin
         s.done_i   = 1'b1;
         s.median_i = pix(0, i);
         tick();
      end
      s.done_i = 1'b0;
      repeat (2) tick();
      check("pre_rst_valid", 64'(s.valid_o), 64'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 64'(s.valid_o), 64'd0);
      check("mid_rst_data", 64'(s.data_o), 64'd0);
      check("mid_rst_sof", 64'(s.sof_o), 64'd0);
      check("mid_rst_eol", 64'(s.eol_o), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);
      check("mid_rst_fdone", 64'(frame_done), 64'd0);
`ifdef MEDIAN_PACK_STATS_EN
      check("mid_rst_min", 64'(min_o), 64'd0);
      check("mid_rst_max", 64'(max_o), 64'd0);
      check("mid_rst_sv", 64'(stats_valid), 64'd0);
`endif
      rst = 1'b0;

      // Frame 4: FIFO full, sink wakes exactly as the fifth word enqueues.
      push_exp(2, 6);
      push_stats(2);
      for (int i = 0; i < 18; i++) begin
         if (i == 16) s.ready_i = 1'b1;
         s.done_i   = 1'b1;
         s.median_i = pix(2, i);
         tick();
      end
      s.done_i = 1'b0;
      wait_drain(60);
      repeat (3) tick();
      check("full_pop_ovf", 64'(overflow), 64'd0);
      check("frames_after_4", 64'(frame_cnt), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
